// File: rtl/br_pred_unit.sv
// Branch resolution and prediction: N/Z/V flag register, 2-bit BHT, mispredict flush and stats.
// Latency: prediction and br_taken are combinational; flush/redirect_pc are registered one cycle after EX. No backpressure.
module br_pred_unit #(
  parameter int         PC_W     = 16,
  parameter int         IDX_W    = 4,
  parameter logic [1:0] CNT_INIT = 2'b01,
  parameter int         STAT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   if_pc,
  input  logic [3:0]        if_opcode,
  input  logic [2:0]        if_br_cond,
  output logic              if_pred_taken,
  input  logic              ex_valid,
  input  logic [3:0]        ex_opcode,
  input  logic [2:0]        ex_br_cond,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic [PC_W-1:0]   ex_target,
  input  logic              ex_pred_taken,
  input  logic              flag_we,
  input  logic              n_in,
  input  logic              z_in,
  input  logic              v_in,
  output logic              br_taken,
  output logic              flush,
  output logic [PC_W-1:0]   redirect_pc,
  output logic [2:0]        flags_q,
  output logic [STAT_W-1:0] br_count,
  output logic [STAT_W-1:0] mispred_count
);

  localparam logic [3:0]        OP_BR       = 4'b1100;
  localparam logic [2:0]        COND_UNCOND = 3'b111;
  localparam int                DEPTH       = 1 << IDX_W;
  localparam logic [PC_W-1:0]   PC_ONE      = 1;
  localparam logic [STAT_W-1:0] STAT_ONE    = 1;
  localparam logic [STAT_W-1:0] STAT_MAX    = '1;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
  } flags_t;

  flags_t           flags;
  logic [1:0]       bht [DEPTH];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [1:0]       ex_cnt;
  logic             ex_is_br;
  logic             cond_true;
  logic             mispredict;
  logic             unused_if_pc_hi;

  assign flags_q         = flags;
  assign if_idx          = if_pc[IDX_W-1:0];
  assign ex_idx          = ex_pc[IDX_W-1:0];
  assign ex_cnt          = bht[ex_idx];
  assign unused_if_pc_hi = ^if_pc[PC_W-1:IDX_W];

  // Wrong-path instructions in the flush shadow are never treated as branches.
  assign ex_is_br   = ex_valid && (ex_opcode == OP_BR) && !flush;
  assign br_taken   = ex_is_br && cond_true;
  assign mispredict = ex_is_br && (br_taken != ex_pred_taken);

  always_comb begin
    cond_true = 1'b0;
    case (ex_br_cond)
      3'b000:  cond_true = ~flags.z;
      3'b001:  cond_true = flags.z;
      3'b010:  cond_true = ~flags.z & ~flags.n;
      3'b011:  cond_true = flags.n;
      3'b100:  cond_true = ~flags.n;
      3'b101:  cond_true = flags.n | flags.z;
      3'b110:  cond_true = flags.v;
      default: cond_true = 1'b1;
    endcase
  end

  always_comb begin
    if_pred_taken = 1'b0;
    if (if_opcode == OP_BR)
      if_pred_taken = (if_br_cond == COND_UNCOND) ? 1'b1 : bht[if_idx][1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      flags <= '0;
    else if (flag_we)
      flags <= '{n: n_in, z: z_in, v: v_in};
  end

  // Unconditional branches are always predicted taken, so they never train the table.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        bht[i] <= CNT_INIT;
    end else if (ex_is_br && (ex_br_cond != COND_UNCOND)) begin
      if (br_taken) begin
        if (ex_cnt != 2'b11)
          bht[ex_idx] <= ex_cnt + 2'd1;
      end else if (ex_cnt != 2'b00) begin
        bht[ex_idx] <= ex_cnt - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush       <= 1'b0;
      redirect_pc <= '0;
    end else begin
      flush <= mispredict;
      if (mispredict)
        redirect_pc <= br_taken ? ex_target : ex_pc + PC_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      if (ex_is_br && (br_count != STAT_MAX))
        br_count <= br_count + STAT_ONE;
      if (mispredict && (mispred_count != STAT_MAX))
        mispred_count <= mispred_count + STAT_ONE;
    end
  end

endmodule

// File: doc/br_pred_unit.md
Name: br_pred_unit

Overview:
Parametrised branch resolution and prediction unit, the successor to the single-cycle branch control. Holds the N/Z/V flag register and a direct-mapped branch history table (BHT) of 2-bit saturating counters. Supplies a taken/not-taken prediction to IF and resolves branches in EX against the registered flags. On a direction mispredict it issues a registered one-cycle flush plus redirect PC back to IF, and keeps saturating branch and mispredict statistics counters.

Parameters:
PC_W, 16, PC width in bits; PC is word-addressed, next sequential PC = pc+1
IDX_W, 4, BHT index width; table depth = 2**IDX_W entries, indexed by pc[IDX_W-1:0]
CNT_INIT, 2'b01, reset value of every BHT counter (weakly not-taken)
STAT_W, 16, width of the statistics counters

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
if_pc  in  PC_W  PC of the instruction in fetch
if_opcode  in  4  predecoded opcode of the fetched instruction
if_br_cond  in  3  branch condition field of the fetched instruction
if_pred_taken  out  1  prediction for the fetched instruction (combinational)
ex_valid  in  1  EX holds a valid, non-squashed instruction
ex_opcode  in  4  opcode in EX
ex_br_cond  in  3  branch condition in EX
ex_pc  in  PC_W  PC of the instruction in EX
ex_target  in  PC_W  computed branch target of the instruction in EX
ex_pred_taken  in  1  prediction made for this instruction at IF, carried down the pipe
flag_we  in  1  ALU result flags valid; load flag register
n_in, z_in, v_in  in  1 each  ALU flags
br_taken  out  1  resolved direction of the EX branch (combinational)
flush  out  1  registered one-cycle pulse: squash IF/ID and redirect
redirect_pc  out  PC_W  registered redirect address, valid while flush=1
flags_q  out  3  registered {N,Z,V}
br_count  out  STAT_W  resolved branches, saturating
mispred_count  out  STAT_W  mispredicts, saturating

Behaviour:
- Reset (async, rst=1): flags_q=0, all BHT entries=CNT_INIT, flush=0, redirect_pc=0, br_count=0, mispred_count=0. Reset mid-flush drops the pulse immediately.
- Branch opcode is 4'b1100. ex_is_br = ex_valid & (ex_opcode==4'b1100) & ~flush.
- Condition evaluation in EX uses flags_q, never same-cycle n_in/z_in/v_in:
  - 000 neq: ~Z
  - 001 eq: Z
  - 010 gt: ~Z & ~N
  - 011 lt: N
  - 100 gte: ~N
  - 101 lte: N | Z
  - 110 ovfl: V
  - 111 uncond: 1
- br_taken = ex_is_br & cond_true.
- Flag register: on flag_we, flags_q <= {n_in,z_in,v_in}; otherwise hold.
- IF prediction:
  - if_pred_taken = 1 when if_opcode==1100 and if_br_cond==111.
  - Otherwise, for opcode 1100, if_pred_taken = BHT[if_pc idx][1].
  - Non-branch opcodes give 0.
- BHT update, only when ex_is_br and ex_br_cond!=111: counter at ex_pc idx increments (saturate 11) if br_taken, else decrements (saturate 00).
- Same-cycle IF read and EX write to the same index: IF sees the pre-update value; no bypass.
- Mispredict = ex_is_br & (br_taken != ex_pred_taken). On the edge where mispredict is true:
  - flush <= 1.
  - redirect_pc <= br_taken ? ex_target : ex_pc+1 (mod 2**PC_W; wraps from all-ones to 0).
  - Otherwise flush <= 0. Latency: 1 cycle from EX resolution to flush.
- While flush=1, EX inputs are treated as wrong-path: no BHT update, no stats, no new mispredict. Flag writes still occur.
- Statistics:
  - br_count increments on every ex_is_br.
  - mispred_count increments on every mispredict.
  - Both hold at all-ones once saturated.
- Back-to-back branches in consecutive cycles with no flush are each resolved and counted independently.

Test Plan:
- Reset, then if_opcode=1100, cond=000, if_pc=0x0005 -> if_pred_taken=0 (CNT_INIT=01); all outputs 0.
- flag_we with z_in=1, then next cycle EX branch cond=001, ex_pred_taken=0, ex_pc=0x0010, ex_target=0x0040 -> br_taken=1; next cycle flush=1, redirect_pc=0x0040; mispred_count=1, br_count=1; BHT[0] becomes 10.
- Same branch twice more, taken -> BHT[0] saturates at 11; a not-taken outcome then sets it to 10 and prediction stays 1.
- Flags N=1,Z=0: cond 101 -> taken; N=0,Z=1: cond 101 -> taken; N=0,Z=0: cond 010 -> taken, cond 101 -> not taken.
- Mispredicted not-taken branch at ex_pc=0xFFFF with ex_pred_taken=1 -> redirect_pc=0x0000. In the flush cycle, assert ex_valid with a branch -> no count change, no second flush.
- Assert rst asynchronously while flush=1 -> flush, counters, and flags_q drop to 0 without waiting for a clock edge. Drive mispred_count to saturation -> it holds at 0xFFFF.
